systolic_mm_top: RTL and testbench
==================================

Name:
systolic_mm_top

Overview:
- Top level of a weight-stationary systolic matrix-multiply engine: computes C = A × W for square ARRAYHEIGHT×ARRAYWIDTH matrices.
- Contains a weight buffer, an input (activation) buffer, an output buffer and a PE array.
- The external controller sequences the buffers through individual enable strobes and streams matrix rows one per cycle.
- C is read back one row per cycle.

Parameters:
- DATASIZE, 8: bits per operand element (unsigned).
- ARRAYWIDTH, 4: PE columns = elements per row. Must equal ARRAYHEIGHT.
- ARRAYHEIGHT, 4: PE rows = rows per matrix.
- OUTPUT_BUF_DATASIZE, 32: bits per result element.
- DSP_DELAY, 1: register stages per PE multiply-accumulate, at least 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- weight_buffer_load_en  in  1  write in_weight into weight buffer at the next row.
- weight_buffer_out_en  in  1  read the next weight-buffer row toward the array.
- write_weight_en  in  1  shift the weight row into the PE array.
- input_buffer_load_en  in  1  write in_act into input buffer at the next row.
- input_buffer_out_en  in  1  stream activations, skewed, into the array.
- output_buffer_load_en  in  1  capture window for array results.
- output_buffer_out_en  in  1  present and advance the output read pointer.
- in_weight  in  DATASIZE*ARRAYWIDTH  one W row; element j at bits [DATASIZE*j +: DATASIZE].
- in_act  in  DATASIZE*ARRAYWIDTH  one A row, same packing.
- out_res  out  OUTPUT_BUF_DATASIZE*ARRAYWIDTH  one C row; element j at bits [OUTPUT_BUF_DATASIZE*j +: OUTPUT_BUF_DATASIZE].

Behaviour:
- Reset (rst=0 at a clk edge):
  - clear all buffer contents and pointers, PE weights, accumulators, pipeline and valid bits;
  - out_res = 0;
  - reset mid-operation aborts the job; the next job starts clean.
- Weight buffer:
  - each load_en cycle writes in_weight to row wr_ptr, wr_ptr++;
  - each out_en cycle reads row rd_ptr, rd_ptr++;
  - both pointers wrap modulo ARRAYHEIGHT.
- Weight preload:
  - each write_weight_en cycle shifts the read row into PE row 0 and shifts existing rows down;
  - after ARRAYHEIGHT cycles, PE(k,j) holds W[k][j], so the row loaded first ends deepest;
  - loading and preloading are back-to-back, one row per cycle, no bubbles.
- Input buffer:
  - each load_en cycle writes row A[i], pointer wraps;
  - may overlap the weight preload cycles.
- Streaming (input_buffer_out_en high):
  - emit A rows 0..ARRAYHEIGHT-1, one per cycle, then zeros;
  - element k of row i enters PE row k delayed k cycles (triangular skew);
  - a valid bit travels with each element.
- PE:
  - psum_out = psum_in + act × weight, computed unsigned and truncated to OUTPUT_BUF_DATASIZE;
  - latency DSP_DELAY;
  - activation passes to the next column and psum passes to the next row, each with matching delay.
- Output buffer:
  - while output_buffer_load_en is high, de-skew the bottom-row results per column;
  - write complete row C[i] when its valid bits arrive, write pointer++;
  - results arriving with load_en low are dropped.
- Latency requirement:
  - all ARRAYHEIGHT result rows are captured within DSP_DELAY*(ARRAYWIDTH-1) + 2*ARRAYHEIGHT*DSP_DELAY cycles;
  - the window starts 2*ARRAYHEIGHT cycles after the first weight load.
- Readout:
  - out_res is combinational: the row at the output read pointer;
  - it is valid in the same cycle output_buffer_out_en rises;
  - each out_en cycle advances the pointer, modulo ARRAYHEIGHT;
  - rows come out in order C[0], C[1], and so on.
- Result definition: C[i][j] = Σk A[i][k]·W[k][j], modulo 2^OUTPUT_BUF_DATASIZE.
- Enables asserted simultaneously on different buffers act independently.

Test Plan:
- Standard flow, W=A with row k = {4k+4, 4k+3, 4k+2, 4k+1} (row 0 = 0x04030201). Expected readout:
  - row0 → lanes {120, 110, 100, 90};
  - row1 → {280, 254, 228, 202}.
- W = identity, A rows 0x04030201, 0x08070605, 0x0c0b0a09, 0x100f0e0d → out_res rows equal A, zero-extended per lane.
- All operands 0xFF: each lane = 4·255² = 260100.
- Reset:
  - hold rst=0 → out_res = 0;
  - assert reset during streaming, then rerun a clean job → correct results, no residue.
- Back-to-back jobs with new weights → the second job's results use only the new W.
- Readout of all ARRAYHEIGHT rows; the pointer wraps to C[0] on a 5th out_en cycle.

Source files
------------

// File: rtl/systolic_mm_top.sv
// Weight-stationary systolic matrix multiply: C = A x W for square matrices.
// Weight, activation and result buffers are sequenced by external enable strobes.
`timescale 1ns/1ps
module systolic_mm_top #(
  parameter int DATASIZE            = 8,
  parameter int ARRAYWIDTH          = 4,
  parameter int ARRAYHEIGHT         = 4,
  parameter int OUTPUT_BUF_DATASIZE = 32,
  parameter int DSP_DELAY           = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      weight_buffer_load_en,
  input  logic                                      weight_buffer_out_en,
  input  logic                                      write_weight_en,
  input  logic                                      input_buffer_load_en,
  input  logic                                      input_buffer_out_en,
  input  logic                                      output_buffer_load_en,
  input  logic                                      output_buffer_out_en,
  input  logic [DATASIZE*ARRAYWIDTH-1:0]            in_weight,
  input  logic [DATASIZE*ARRAYWIDTH-1:0]            in_act,
  output logic [OUTPUT_BUF_DATASIZE*ARRAYWIDTH-1:0] out_res
);
  localparam int AW = ARRAYWIDTH;
  localparam int AH = ARRAYHEIGHT;
  localparam int DS = DATASIZE;
  localparam int OW = OUTPUT_BUF_DATASIZE;
  localparam int D  = DSP_DELAY;
  localparam int RW = DS * AW;
  localparam int PW = (AH > 1) ? $clog2(AH) : 1;
  localparam int CW = PW + 1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(AH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Weight buffer; rows are read combinationally at the read pointer.
  logic [RW-1:0] wbuf [AH];
  logic [PW-1:0] wb_wr_ptr, wb_rd_ptr;
  logic [RW-1:0] w_rd_row;

  assign w_rd_row = wbuf[wb_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < AH; i++) wbuf[i] <= '0;
      wb_wr_ptr <= '0;
      wb_rd_ptr <= '0;
    end else begin
      if (weight_buffer_load_en) begin
        wbuf[wb_wr_ptr] <= in_weight;
        wb_wr_ptr       <= ptr_inc(wb_wr_ptr);
      end
      if (weight_buffer_out_en) wb_rd_ptr <= ptr_inc(wb_rd_ptr);
    end
  end

  // Stationary weights: new rows enter PE row 0, older rows sink one row deeper.
  logic [DS-1:0] pe_w [AH][AW];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < AH; k++)
        for (int j = 0; j < AW; j++) pe_w[k][j] <= '0;
    end else if (write_weight_en) begin
      for (int j = 0; j < AW; j++) begin
        pe_w[0][j] <= w_rd_row[j*DS +: DS];
        for (int k = 1; k < AH; k++) pe_w[k][j] <= pe_w[k-1][j];
      end
    end
  end

  // Input buffer and row streamer: AH valid rows per out_en burst, then zeros.
  logic [RW-1:0] ibuf [AH];
  logic [PW-1:0] ib_wr_ptr, ib_rd_ptr;
  logic [CW-1:0] strm_cnt;
  logic          strm_active;
  logic [RW-1:0] strm_row;

  assign strm_active = input_buffer_out_en && (strm_cnt < CW'(AH));
  assign strm_row    = strm_active ? ibuf[ib_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < AH; i++) ibuf[i] <= '0;
      ib_wr_ptr <= '0;
      ib_rd_ptr <= '0;
      strm_cnt  <= '0;
    end else begin
      if (input_buffer_load_en) begin
        ibuf[ib_wr_ptr] <= in_act;
        ib_wr_ptr       <= ptr_inc(ib_wr_ptr);
      end
      if (!input_buffer_out_en) begin
        strm_cnt <= '0;
      end else if (strm_active) begin
        strm_cnt  <= strm_cnt + CW'(1);
        ib_rd_ptr <= ptr_inc(ib_rd_ptr);
      end
    end
  end

  // Activation lanes carry {valid, data}; lane k is delayed k*D to meet its psum.
  logic [DS:0]   act_bus  [AH][AW+1];
  logic [OW-1:0] psum_bus [AH+1][AW];

  for (genvar k = 0; k < AH; k++) begin : g_skew
    localparam int N = k * D;
    logic [DS:0] lane_in;
    assign lane_in = {strm_active, strm_row[k*DS +: DS]};
    if (N == 0) begin : g_direct
      assign act_bus[k][0] = lane_in;
    end else begin : g_delay
      logic [DS:0] sr [N];
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int s = 0; s < N; s++) sr[s] <= '0;
        end else begin
          sr[0] <= lane_in;
          for (int s = 1; s < N; s++) sr[s] <= sr[s-1];
        end
      end
      assign act_bus[k][0] = sr[N-1];
    end
  end

  for (genvar j = 0; j < AW; j++) begin : g_top_psum
    assign psum_bus[0][j] = '0;
  end

  for (genvar k = 0; k < AH; k++) begin : g_row
    for (genvar j = 0; j < AW; j++) begin : g_col
      logic [2*DS-1:0] prod;
      logic [OW-1:0]   mac;
      logic [DS:0]     a_pipe [D];
      logic [OW-1:0]   p_pipe [D];

      assign prod = {{DS{1'b0}}, act_bus[k][j][DS-1:0]} * {{DS{1'b0}}, pe_w[k][j]};
      assign mac  = psum_bus[k][j] + OW'(prod);

      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int s = 0; s < D; s++) begin
            a_pipe[s] <= '0;
            p_pipe[s] <= '0;
          end
        end else begin
          a_pipe[0] <= act_bus[k][j];
          p_pipe[0] <= mac;
          for (int s = 1; s < D; s++) begin
            a_pipe[s] <= a_pipe[s-1];
            p_pipe[s] <= p_pipe[s-1];
          end
        end
      end

      assign act_bus[k][j+1]  = a_pipe[D-1];
      assign psum_bus[k+1][j] = p_pipe[D-1];
    end
  end

  // De-skew: column j waits (AW-1-j)*D so one result row lines up across columns.
  logic [AW-1:0]    row_vld;
  logic [OW*AW-1:0] res_row;

  for (genvar j = 0; j < AW; j++) begin : g_deskew
    localparam int N = (AW - 1 - j) * D;
    logic [OW:0] lane_in;
    logic [OW:0] lane_out;
    assign lane_in = {act_bus[AH-1][j+1][DS], psum_bus[AH][j]};
    if (N == 0) begin : g_direct
      assign lane_out = lane_in;
    end else begin : g_delay
      logic [OW:0] sr [N];
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int s = 0; s < N; s++) sr[s] <= '0;
        end else begin
          sr[0] <= lane_in;
          for (int s = 1; s < N; s++) sr[s] <= sr[s-1];
        end
      end
      assign lane_out = sr[N-1];
    end
    assign row_vld[j]           = lane_out[OW];
    assign res_row[j*OW +: OW]  = lane_out[OW-1:0];
  end

  // Output buffer: rows arriving outside the load window are discarded.
  logic [OW*AW-1:0] obuf [AH];
  logic [PW-1:0]    ob_wr_ptr, ob_rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < AH; i++) obuf[i] <= '0;
      ob_wr_ptr <= '0;
      ob_rd_ptr <= '0;
    end else begin
      if (output_buffer_load_en && (&row_vld)) begin
        obuf[ob_wr_ptr] <= res_row;
        ob_wr_ptr       <= ptr_inc(ob_wr_ptr);
      end
      if (output_buffer_out_en) ob_rd_ptr <= ptr_inc(ob_rd_ptr);
    end
  end

  assign out_res = obuf[ob_rd_ptr];

endmodule

// File: tb/tb_systolic_mm_top.sv
// Directed bench for systolic_mm_top: drivers push expected C rows into a queue,
// a negedge monitor pops and compares each row presented under output_buffer_out_en.
`timescale 1ns/1ps
module tb_systolic_mm_top;
  typedef logic [31:0]  row_t;
  typedef logic [127:0] res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        weight_buffer_load_en, weight_buffer_out_en, write_weight_en;
  logic        input_buffer_load_en, input_buffer_out_en;
  logic        output_buffer_load_en, output_buffer_out_en;
  logic [31:0] in_weight, in_act;
  logic [127:0] out_res;

  logic [127:0] exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  finish_req = 1'b0;
  bit  report_done = 1'b0;
  bit  timed_out = 1'b0;

  systolic_mm_top #(
    .DATASIZE(8), .ARRAYWIDTH(4), .ARRAYHEIGHT(4),
    .OUTPUT_BUF_DATASIZE(32), .DSP_DELAY(1)
  ) dut (
    .clk(clk), .rst(rst),
    .weight_buffer_load_en(weight_buffer_load_en),
    .weight_buffer_out_en(weight_buffer_out_en),
    .write_weight_en(write_weight_en),
    .input_buffer_load_en(input_buffer_load_en),
    .input_buffer_out_en(input_buffer_out_en),
    .output_buffer_load_en(output_buffer_load_en),
    .output_buffer_out_en(output_buffer_out_en),
    .in_weight(in_weight), .in_act(in_act), .out_res(out_res)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: C[i][j] = sum_k A[i][k] * W[k][j] mod 2^32
  function automatic res_t mm_row(input row_t w [4], input row_t a);
    res_t r;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      logic [31:0] acc;
      acc = '0;
      for (int k = 0; k < 4; k++)
        acc = acc + 32'(a[8*k +: 8]) * 32'(w[k][8*j +: 8]);
      r[32*j +: 32] = acc;
    end
    return r;
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    weight_buffer_load_en = 1'b0;
    weight_buffer_out_en  = 1'b0;
    write_weight_en       = 1'b0;
    input_buffer_load_en  = 1'b0;
    input_buffer_out_en   = 1'b0;
    output_buffer_load_en = 1'b0;
    output_buffer_out_en  = 1'b0;
    in_weight             = '0;
    in_act                = '0;
  endtask

  // W rows go in deepest-first so PE row k ends up holding W[k].
  task automatic run_job(input row_t w [4], input row_t a [4], input int abort_at);
    bit aborted;
    aborted = 1'b0;
    for (int c = 0; c < 20 && !aborted; c++) begin
      clear_inputs();
      if (c < 4) begin
        weight_buffer_load_en = 1'b1;
        in_weight             = w[3-c];
      end
      if (c >= 4 && c < 8) begin
        weight_buffer_out_en = 1'b1;
        write_weight_en      = 1'b1;
        input_buffer_load_en = 1'b1;
        in_act               = a[c-4];
      end
      if (c >= 8 && c < 12) input_buffer_out_en = 1'b1;
      if (c >= 8 && c < 19) output_buffer_load_en = 1'b1;
      if (c == abort_at) begin
        rst = 1'b0;
        step();
        step();
        aborted = 1'b1;
        clear_inputs();
        rst = 1'b1;
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic read_rows(input res_t e [4], input int n);
    for (int r = 0; r < n; r++) begin
      exp_q.push_back(e[r % 4]);
      output_buffer_out_en = 1'b1;
      step();
    end
    output_buffer_out_en = 1'b0;
    step();
  endtask

  task automatic reset_check(input int n);
    rst = 1'b0;
    for (int r = 0; r < n; r++) begin
      exp_q.push_back('0);
      output_buffer_out_en = 1'b1;
      step();
    end
    output_buffer_out_en = 1'b0;
    rst = 1'b1;
    step();
  endtask

  task automatic build_exp(input row_t w [4], input row_t a [4], output res_t e [4]);
    for (int i = 0; i < 4; i++) e[i] = mm_row(w, a[i]);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (output_buffer_out_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL readout: row %h presented with nothing expected", out_res);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        if (out_res !== e) begin
          n_fail++;
          $display("FAIL readout: got %h expected %h", out_res, e);
        end
      end
    end
    if (finish_req && !report_done) begin
      n_checks++;
      if (exp_q.size() != 0 || timed_out) begin
        n_fail++;
        $display("FAIL drain: %0d rows still expected, timeout=%0d, required 0 and 0",
                 exp_q.size(), timed_out);
      end
      report_done = 1'b1;
    end
  end

  row_t seq   [4] = '{32'h04030201, 32'h08070605, 32'h0c0b0a09, 32'h100f0e0d};
  row_t ident [4] = '{32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000};
  row_t ffs   [4] = '{32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff};

  initial begin
    res_t e [4];
    rst = 1'b0;
    clear_inputs();
    fork
      begin
        step();
        // Reset state: out_res reads zero while reset is held
        reset_check(2);

        // Standard flow W = A = seq; rows 0/1 hand-computed
        run_job(seq, seq, -1);
        build_exp(seq, seq, e);
        e[0] = {32'd120, 32'd110, 32'd100, 32'd90};
        e[1] = {32'd280, 32'd254, 32'd228, 32'd202};
        read_rows(e, 4);

        // Identity weights: C == A, zero-extended
        run_job(ident, seq, -1);
        e[0] = {32'h04, 32'h03, 32'h02, 32'h01};
        e[1] = {32'h08, 32'h07, 32'h06, 32'h05};
        e[2] = {32'h0c, 32'h0b, 32'h0a, 32'h09};
        e[3] = {32'h10, 32'h0f, 32'h0e, 32'h0d};
        read_rows(e, 4);

        // All-ones operands: 4 * 255^2 = 260100 per lane
        run_job(ffs, ffs, -1);
        for (int i = 0; i < 4; i++) e[i] = {4{32'd260100}};
        read_rows(e, 4);

        // Reset mid-stream, confirm cleared outputs, then a clean job
        run_job(seq, ffs, 10);
        reset_check(2);
        run_job(ffs, seq, -1);
        build_exp(ffs, seq, e);
        read_rows(e, 4);

        // New weights, identity activations (C == W); fifth read wraps to C[0]
        run_job(seq, ident, -1);
        build_exp(seq, ident, e);
        read_rows(e, 5);
      end
      begin
        #100000;
        timed_out = 1'b1;
      end
    join_any
    disable fork;
    clear_inputs();
    finish_req = 1'b1;
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
